// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard, forwarding and flush control for the 5-stage pipeline, with a
// scoreboard for the multi-cycle mul/div unit and a saturating stall counter.
module pipeline_hazard_scoreboard #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MD_LATENCY  = 4,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_AW-1:0]      rs_decode,
  input  logic [REG_AW-1:0]      rt_decode,
  input  logic                   uses_rs_decode,
  input  logic                   uses_rt_decode,
  input  logic                   md_op_decode,
  input  logic [REG_AW-1:0]      rs_exe,
  input  logic [REG_AW-1:0]      rt_exe,
  input  logic [REG_AW-1:0]      wreg_dst_exe,
  input  logic                   reg_we_exe,
  input  logic                   is_load_exe,
  input  logic                   md_start_exe,
  input  logic                   branch_taken_exe,
  input  logic [REG_AW-1:0]      wreg_dst_dm,
  input  logic                   reg_we_dm,
  input  logic [REG_AW-1:0]      wreg_dst_wrbck,
  input  logic                   reg_we_wrbck,
  output logic                   stall_fetch,
  output logic                   stall_decode,
  output logic                   clear_exe,
  output logic                   flush_decode,
  output logic [1:0]             forward_srca_sel_exe,
  output logic [1:0]             forward_srcb_sel_exe,
  output logic                   md_busy,
  output logic                   md_wb_valid,
  output logic [REG_AW-1:0]      md_wb_dst,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int unsigned NUM_REGS = 2 ** REG_AW;
  localparam logic [3:0]  LAT      = 4'(MD_LATENCY);

  logic [3:0]             r_md_cnt;
  logic [NUM_REGS-1:0]    r_pending;
  logic [REG_AW-1:0]      r_md_wb_dst;
  logic [STALL_CNT_W-1:0] r_stall_count;

  logic w_md_busy;
  logic w_load_hz;
  logic w_sb_hz;
  logic w_stall;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] dst_dm,
    input logic              we_dm,
    input logic [REG_AW-1:0] dst_wb,
    input logic              we_wb
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0 && src == dst_dm && we_dm)
      sel = 2'b10;
    else if (src != '0 && src == dst_wb && we_wb)
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    forward_srca_sel_exe = fwd_sel(rs_exe, wreg_dst_dm, reg_we_dm, wreg_dst_wrbck, reg_we_wrbck);
    forward_srcb_sel_exe = fwd_sel(rt_exe, wreg_dst_dm, reg_we_dm, wreg_dst_wrbck, reg_we_wrbck);
  end

  always_comb begin
    w_md_busy = (r_md_cnt != '0);
    w_load_hz = is_load_exe && reg_we_exe && (wreg_dst_exe != '0) &&
                ((uses_rs_decode && rs_decode == wreg_dst_exe) ||
                 (uses_rt_decode && rt_decode == wreg_dst_exe));
    // Pending bits stay set through the write-back cycle, so readers are
    // released only once the register file holds the MD result.
    w_sb_hz   = (uses_rs_decode && r_pending[rs_decode]) ||
                (uses_rt_decode && r_pending[rt_decode]) ||
                (md_op_decode && w_md_busy);
    w_stall   = (w_load_hz || w_sb_hz) && !branch_taken_exe;
  end

  always_comb begin
    stall_fetch  = w_stall;
    stall_decode = w_stall;
    clear_exe    = w_stall || branch_taken_exe;
    flush_decode = branch_taken_exe;
    md_busy      = w_md_busy;
    md_wb_valid  = (r_md_cnt == 4'd1);
    md_wb_dst    = r_md_wb_dst;
    stall_count  = r_stall_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt      <= '0;
      r_pending     <= '0;
      r_md_wb_dst   <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_stall && r_stall_count != '1)
        r_stall_count <= r_stall_count + STALL_CNT_W'(1);
      // Accept only when idle; a start while busy is dropped.
      if (w_md_busy) begin
        r_md_cnt <= r_md_cnt - 4'd1;
        if (r_md_cnt == 4'd1)
          r_pending[r_md_wb_dst] <= 1'b0;
      end else if (md_start_exe) begin
        r_md_cnt    <= LAT;
        r_md_wb_dst <= wreg_dst_exe;
        if (wreg_dst_exe != '0)
          r_pending[wreg_dst_exe] <= 1'b1;
      end
    end
  end

endmodule
